// File: rtl/change_dispenser.sv
// Coin payout controller: queues owed 1/2-unit coins and drives the hopper one coin at a time.
// Optional paid1/paid2 drop counters are enabled by defining CHANGE_DISPENSER_STATS_EN.
module change_dispenser #(
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             change1,
   input  logic             change2,
   input  logic             change22,
   input  logic             drop1,
   input  logic             drop2,
   output logic             eject1,
   output logic             eject2,
   output logic [CNT_W-1:0] pend1,
   output logic [CNT_W-1:0] pend2,
   output logic             busy,
   output logic             jam,
`ifdef CHANGE_DISPENSER_STATS_EN
   output logic [15:0]      paid1,
   output logic [15:0]      paid2,
`endif
   output logic             overflow
);

   localparam int unsigned TMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
   localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] GapLast     = TW'(GAP_CYCLES - 1);
   localparam logic [CNT_W+1:0] PendMax  = {2'b00, {CNT_W{1'b1}}};

   typedef enum logic [2:0] {StIdle, StEj2, StEj1, StGap, StJam} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] pend1_q, pend1_d, pend2_q, pend2_d;
   logic             overflow_q, overflow_d;
   logic             dec1, dec2;
   logic [1:0]       inc2;
   logic [CNT_W+1:0] sum1, sum2;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dec1    = 1'b0;
      dec2    = 1'b0;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (pend2_q != '0) begin
               state_d = StEj2;
            end else if (pend1_q != '0) begin
               state_d = StEj1;
            end
         end
         StEj2: begin
            if (drop2) begin
               dec2    = 1'b1;
               state_d = StGap;
               timer_d = '0;
            end else if (timer_q == TimeoutLast) begin
               state_d = StJam;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StEj1: begin
            if (drop1) begin
               dec1    = 1'b1;
               state_d = StGap;
               timer_d = '0;
            end else if (timer_q == TimeoutLast) begin
               state_d = StJam;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StGap: begin
            if (timer_q == GapLast) begin
               state_d = StIdle;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StJam: ;
         default: state_d = StIdle;
      endcase
   end

   // Accounting runs in every state, JAM included; a drop only counts while its eject is up.
   always_comb begin
      inc2       = {1'b0, change2} + {change22, 1'b0};
      sum1       = {2'b00, pend1_q} + (CNT_W+2)'(change1) - (CNT_W+2)'(dec1);
      sum2       = {2'b00, pend2_q} + (CNT_W+2)'(inc2) - (CNT_W+2)'(dec2);
      overflow_d = overflow_q;
      pend1_d    = sum1[CNT_W-1:0];
      pend2_d    = sum2[CNT_W-1:0];
      if (sum1 > PendMax) begin
         pend1_d    = '1;
         overflow_d = 1'b1;
      end
      if (sum2 > PendMax) begin
         pend2_d    = '1;
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         pend1_q    <= '0;
         pend2_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pend1_q    <= pend1_d;
         pend2_q    <= pend2_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef CHANGE_DISPENSER_STATS_EN
   logic [15:0] paid1_q, paid2_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         paid1_q <= '0;
         paid2_q <= '0;
      end else begin
         paid1_q <= paid1_q + 16'(dec1);
         paid2_q <= paid2_q + 16'(dec2);
      end
   end

   assign paid1 = paid1_q;
   assign paid2 = paid2_q;
`endif

   assign eject1   = (state_q == StEj1);
   assign eject2   = (state_q == StEj2);
   assign jam      = (state_q == StJam);
   assign pend1    = pend1_q;
   assign pend2    = pend2_q;
   assign overflow = overflow_q;
   assign busy     = (pend1_q != '0) || (pend2_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus a per-cycle comparison against a
// coin-queue model (CHANGE_DISPENSER_STATS_EN adds the paid counters to both).
module tb_change_dispenser;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 20;
   localparam int unsigned GAP     = 4;
   localparam int          MaxPend = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic change1 = 1'b0, change2 = 1'b0, change22 = 1'b0, drop1 = 1'b0, drop2 = 1'b0;
   logic eject1, eject2, busy, jam, overflow;
   logic [CNT_W-1:0] pend1, pend2;
`ifdef CHANGE_DISPENSER_STATS_EN
   logic [15:0] paid1, paid2;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   bit run    = 1'b0;

   change_dispenser #(
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT),
      .GAP_CYCLES    (GAP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .change1 (change1),
      .change2 (change2),
      .change22(change22),
      .drop1   (drop1),
      .drop2   (drop2),
      .eject1  (eject1),
      .eject2  (eject2),
      .pend1   (pend1),
      .pend2   (pend2),
      .busy    (busy),
      .jam     (jam),
`ifdef CHANGE_DISPENSER_STATS_EN
      .paid1   (paid1),
      .paid2   (paid2),
`endif
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: owed coin counts, which coin is being offered and for how long, remaining quiet time.
   int m_p1, m_p2, m_coin, m_age, m_quiet, m_paid1, m_paid2;
   bit m_jam, m_ovf;
   int i1, i2, d1, d2;

   always @(posedge clk) begin
      if (!reset) begin
         m_p1 = 0; m_p2 = 0; m_coin = 0; m_age = 0; m_quiet = 0;
         m_jam = 0; m_ovf = 0; m_paid1 = 0; m_paid2 = 0;
      end else begin
         i1 = int'(change1);
         i2 = int'(change2) + 2 * int'(change22);
         d1 = 0;
         d2 = 0;
         if (!m_jam) begin
            if (m_coin != 0) begin
               if (m_coin == 1 && drop1) d1 = 1;
               if (m_coin == 2 && drop2) d2 = 1;
               if (d1 + d2 != 0) begin
                  m_coin  = 0;
                  m_quiet = GAP;
               end else if (m_age == TIMEOUT) begin
                  m_coin = 0;
                  m_jam  = 1;
               end else begin
                  m_age++;
               end
            end else if (m_quiet > 0) begin
               m_quiet--;
            end else if (m_p2 > 0) begin
               m_coin = 2; m_age = 1;
            end else if (m_p1 > 0) begin
               m_coin = 1; m_age = 1;
            end
         end
         m_p1 = m_p1 + i1 - d1;
         m_p2 = m_p2 + i2 - d2;
         if (m_p1 > MaxPend) begin m_p1 = MaxPend; m_ovf = 1; end
         if (m_p2 > MaxPend) begin m_p2 = MaxPend; m_ovf = 1; end
         m_paid1 = (m_paid1 + d1) % 65536;
         m_paid2 = (m_paid2 + d2) % 65536;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         check("m_eject1", 32'(eject1), 32'(m_coin == 1 && !m_jam));
         check("m_eject2", 32'(eject2), 32'(m_coin == 2 && !m_jam));
         check("m_pend1", 32'(pend1), m_p1);
         check("m_pend2", 32'(pend2), m_p2);
         check("m_busy", 32'(busy),
               32'(m_p1 != 0 || m_p2 != 0 || m_coin != 0 || m_quiet != 0 || m_jam));
         check("m_jam", 32'(jam), 32'(m_jam));
         check("m_overflow", 32'(overflow), 32'(m_ovf));
         check("m_no_overlap", 32'(eject1 & eject2), 0);
`ifdef CHANGE_DISPENSER_STATS_EN
         check("m_paid1", 32'(paid1), m_paid1);
         check("m_paid2", 32'(paid2), m_paid2);
`endif
      end
   end

   task automatic step(input bit c1, input bit c2, input bit c22, input bit dr1, input bit dr2);
      change1 = c1; change2 = c2; change22 = c22; drop1 = dr1; drop2 = dr2;
      @(negedge clk);
      change1 = 0; change2 = 0; change22 = 0; drop1 = 0; drop2 = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
   endtask

   // Steps until the requested eject is high; w = steps taken.
   task automatic wait_eject(input int which, output int w);
      w = 0;
      while (!((which == 1) ? eject1 : eject2) && w < 50) begin
         idle(1);
         w++;
      end
      check("eject_seen", 32'((which == 1) ? eject1 : eject2), 1);
   endtask

   // Waits for the eject, keeps it up for hold more cycles, then drops the coin.
   task automatic serve(input int which, input int hold, output int w);
      wait_eject(which, w);
      idle(hold);
      step(0, 0, 0, which == 1, which == 2);
   endtask

   int w, k;

   initial begin
      @(negedge clk);
      check("rst_pend1", 32'(pend1), 0);
      check("rst_eject", 32'({eject1, eject2, busy, jam, overflow}), 0);
      reset = 1'b1;
      run   = 1'b1;

      // 1: single 1-unit coin, eject up for 3 cycles
      step(1, 0, 0, 0, 0);
      check("t1_pend1_n1", 32'(pend1), 1);
      check("t1_eject1_n1", 32'(eject1), 0);
      serve(1, 2, w);
      check("t1_latency", w, 1);
      check("t1_pend1_after", 32'(pend1), 0);
      check("t1_eject1_after", 32'(eject1), 0);
      idle(3);
      check("t1_busy_gap", 32'(busy), 1);
      idle(1);
      check("t1_busy_idle", 32'(busy), 0);

      // 2: change22, two windows separated by GAP+1 low cycles
      do_reset();
      step(0, 0, 1, 0, 0);
      check("t2_pend2", 32'(pend2), 2);
      serve(2, 1, w);
      check("t2_latency", w, 1);
      serve(2, 1, w);
      check("t2_low_cycles", w, GAP + 1);
      check("t2_pend2_end", 32'(pend2), 0);
`ifdef CHANGE_DISPENSER_STATS_EN
      check("t2_paid2", 32'(paid2), 2);
`endif

      // 3: both at once; 2-unit first, foreign drop ignored
      do_reset();
      step(1, 1, 0, 0, 0);
      check("t3_pend1", 32'(pend1), 1);
      check("t3_pend2", 32'(pend2), 1);
      wait_eject(2, w);
      check("t3_eject1_low", 32'(eject1), 0);
      step(0, 0, 0, 1, 0);
      check("t3_foreign_drop", 32'(pend1), 1);
      check("t3_still_ej2", 32'(eject2), 1);
      step(0, 0, 0, 0, 1);
      serve(1, 0, w);
      check("t3_gap_then_ej1", w, GAP + 1);
      check("t3_pend1_end", 32'(pend1), 0);

      // 4: jam after TIMEOUT cycles of eject2
      do_reset();
      step(0, 1, 0, 0, 0);
      wait_eject(2, w);
      k = 1;
      while (k < 100) begin
         idle(1);
         if (!eject2) break;
         k++;
      end
      check("t4_high_cycles", k, TIMEOUT);
      check("t4_jam", 32'(jam), 1);
      check("t4_model_jam", 32'(m_jam), 1);
      step(1, 0, 0, 0, 1);
      idle(3);
      check("t4_pend1", 32'(pend1), 1);
      check("t4_pend2_kept", 32'(pend2), 1);
      check("t4_no_eject", 32'({eject1, eject2}), 0);
      check("t4_jam_sticky", 32'(jam), 1);

      // 5: saturation and sticky overflow
      do_reset();
      for (int n = 0; n < 7; n++) step(0, 0, 1, 0, 0);
      check("t5_pend2_14", 32'(pend2), 14);
      check("t5_no_ovf", 32'(overflow), 0);
      step(0, 0, 1, 0, 0);
      check("t5_pend2_sat", 32'(pend2), MaxPend);
      check("t5_model_sat", m_p2, 15);
      check("t5_ovf", 32'(overflow), 1);
      idle(4);
      check("t5_ovf_sticky", 32'(overflow), 1);

      // drop and request for the same coin together: net zero
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      wait_eject(1, w);
      step(1, 0, 0, 1, 0);
      check("t7_net_zero", 32'(pend1), 2);

      // 6: reset while eject2 high with pend2=2
      do_reset();
      step(0, 1, 1, 0, 0);
      serve(2, 0, w);
      wait_eject(2, w);
      check("t6_pend2_pre", 32'(pend2), 2);
      reset = 1'b0;
      idle(1);
      check("t6_eject2", 32'(eject2), 0);
      check("t6_pend2", 32'(pend2), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_jam", 32'(jam), 0);
`ifdef CHANGE_DISPENSER_STATS_EN
      check("t6_paid", 32'({paid1, paid2}), 0);
`endif
      reset = 1'b1;
      idle(2);

      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
